// File: rtl/branch_predictor.sv
//==============================================================================
// Module : branch_predictor
// 16-entry direct-mapped BTB with 2-bit counters; optional gshare counter
// indexing and history repair enabled by macro BP_GSHARE_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module branch_predictor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic [3:0]  pred_ghr,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    input  logic [3:0]  upd_ghr,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [15:0] mispred_cnt
);

    localparam int unsigned ENTRIES   = 16;
    localparam int unsigned TAG_W     = 26;
    localparam logic [1:0]  CTR_RESET = 2'b01;
    localparam logic [1:0]  CTR_ALLOC = 2'b10;
    localparam logic [1:0]  CTR_MAX   = 2'b11;
    localparam logic [1:0]  CTR_MIN   = 2'b00;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [15:0]        r_mispred_cnt;

    logic [3:0]  w_lk_idx;
    logic [3:0]  w_lk_cidx;
    logic [3:0]  w_up_idx;
    logic [3:0]  w_up_cidx;
    logic [3:0]  w_ghr;
    logic        w_lk_hit;
    logic        w_up_hit;
    logic [31:0] w_if_pc_plus4;
    logic [31:0] w_upd_pc_plus4;

    assign w_lk_idx = if_pc[5:2];
    assign w_up_idx = upd_pc[5:2];

`ifdef BP_GSHARE_EN
    logic [3:0] r_ghr;

    // A mispredict rebuilds history from the branch's own snapshot so that
    // outcomes shifted in on the wrong path are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= 4'b0000;
        end else if (upd_valid) begin
            if (mispredict) begin
                r_ghr <= {upd_ghr[2:0], upd_taken};
            end else begin
                r_ghr <= {r_ghr[2:0], upd_taken};
            end
        end
    end

    assign w_ghr     = r_ghr;
    assign w_lk_cidx = w_lk_idx ^ r_ghr;
    assign w_up_cidx = w_up_idx ^ upd_ghr;

    logic w_unused;
    assign w_unused = ^{if_pc[1:0], upd_pc[1:0]};
`else
    assign w_ghr     = 4'b0000;
    assign w_lk_cidx = w_lk_idx;
    assign w_up_cidx = w_up_idx;

    logic w_unused;
    assign w_unused = ^{upd_ghr, if_pc[1:0], upd_pc[1:0]};
`endif

    assign w_if_pc_plus4  = if_pc + 32'd4;
    assign w_upd_pc_plus4 = upd_pc + 32'd4;

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == if_pc[31:6]);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == upd_pc[31:6]);

    assign pred_taken  = w_lk_hit && r_ctr[w_lk_cidx][1];
    assign pred_target = pred_taken ? r_target[w_lk_idx] : w_if_pc_plus4;
    assign pred_ghr    = w_ghr;

    assign mispredict  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : w_upd_pc_plus4;
    assign mispred_cnt = r_mispred_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken && (r_ctr[w_up_cidx] != CTR_MAX)) begin
                    r_ctr[w_up_cidx] <= r_ctr[w_up_cidx] + 2'b01;
                end else if (!upd_taken && (r_ctr[w_up_cidx] != CTR_MIN)) begin
                    r_ctr[w_up_cidx] <= r_ctr[w_up_cidx] - 2'b01;
                end
            end else if (upd_taken) begin
                r_valid[w_up_idx]  <= 1'b1;
                r_ctr[w_up_cidx]   <= CTR_ALLOC;
            end
        end
    end

    // Tag/target writes during reset are harmless: valid stays clear and
    // any later allocation rewrites both fields.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            r_tag[w_up_idx]    <= upd_pc[31:6];
            r_target[w_up_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispred_cnt <= 16'h0000;
        end else if (mispredict && (r_mispred_cnt != CNT_MAX)) begin
            r_mispred_cnt <= r_mispred_cnt + 16'h0001;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//==============================================================================
// Module : tb_branch_predictor
// Directed stimulus against a table-level reference model of branch_predictor.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'h100;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_ghr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic [3:0]  upd_ghr = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] mispred_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays of entry fields, counters as integers.
    bit          m_valid  [16];
    int unsigned m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16] = '{default: 1};
    int          m_cnt = 0;
    int          m_ghr = 0;

    function automatic int ent(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic int cid(input logic [31:0] pc, input int h);
`ifdef BP_GSHARE_EN
        return ent(pc) ^ h;
`else
        return ent(pc) + 0 * h;
`endif
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[ent(pc)] && (m_tag[ent(pc)] == int'(pc / 64));
    endfunction

    function automatic bit m_mispredict();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_cnt = 0;
            m_ghr = 0;
        end else begin
            if (m_mispredict() && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (upd_valid) begin
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        if (m_ctr[cid(upd_pc, int'(upd_ghr))] < 3)
                            m_ctr[cid(upd_pc, int'(upd_ghr))] += 1;
                        m_target[ent(upd_pc)] = upd_target;
                    end else if (m_ctr[cid(upd_pc, int'(upd_ghr))] > 0) begin
                        m_ctr[cid(upd_pc, int'(upd_ghr))] -= 1;
                    end
                end else if (upd_taken) begin
                    m_valid[ent(upd_pc)]  = 1'b1;
                    m_tag[ent(upd_pc)]    = int'(upd_pc / 64);
                    m_target[ent(upd_pc)] = upd_target;
                    m_ctr[cid(upd_pc, int'(upd_ghr))] = 2;
                end
`ifdef BP_GSHARE_EN
                if (m_mispredict()) m_ghr = ((int'(upd_ghr) * 2) + int'(upd_taken)) % 16;
                else                m_ghr = ((m_ghr * 2) + int'(upd_taken)) % 16;
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_pt;
            bit          e_mp;
            logic [31:0] e_tgt;
            logic [31:0] e_red;
            e_pt  = m_hit(if_pc) && (m_ctr[cid(if_pc, m_ghr)] >= 2);
            e_tgt = e_pt ? m_target[ent(if_pc)] : if_pc + 32'd4;
            e_mp  = m_mispredict();
            e_red = upd_taken ? upd_target : upd_pc + 32'd4;
            n_vec++;
            if (pred_taken !== e_pt || pred_target !== e_tgt || pred_ghr !== 4'(m_ghr) ||
                mispredict !== e_mp || (e_mp && redirect_pc !== e_red) ||
                mispred_cnt !== 16'(m_cnt)) begin
                n_err++;
                $display("FAIL model t=%0t pc=%h: pt=%b/%b tgt=%h/%h ghr=%h/%h mp=%b/%b red=%h/%h cnt=%h/%h (got/exp)",
                         $time, if_pc, pred_taken, e_pt, pred_target, e_tgt, pred_ghr, 4'(m_ghr),
                         mispredict, e_mp, redirect_pc, e_red, mispred_cnt, 16'(m_cnt));
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic v, input logic [31:0] upc,
                         input logic [31:0] utgt, input logic ut, input logic upt,
                         input logic [31:0] uptgt, input logic [3:0] ug);
        if_pc = pc; upd_valid = v; upd_pc = upc; upd_target = utgt;
        upd_taken = ut; upd_pred_taken = upt; upd_pred_target = uptgt; upd_ghr = ug;
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle(32'h100);
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        lit("reset_pt", {31'b0, pred_taken}, 32'h0);
        lit("reset_tgt", pred_target, 32'h104);
        lit("reset_cnt", {16'b0, mispred_cnt}, 32'h0);
        next();
        rst_n = 1'b1;

`ifdef BP_GSHARE_EN
        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 4'h0);
        next();
        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 4'h1);
        next();
        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 32'h104, 4'h3);
        next();
        idle(32'h100);
        @(negedge clk);
        lit("ghr_ttn", {28'b0, pred_ghr}, 32'h6);
        next();
        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h104, 4'hA);
        @(negedge clk);
        lit("ghr_mp", {31'b0, mispredict}, 32'h1);
        next();
        idle(32'h100);
        @(negedge clk);
        lit("ghr_repair", {28'b0, pred_ghr}, 32'h5);
        next();
`else
        @(negedge clk);
        lit("cold_pt", {31'b0, pred_taken}, 32'h0);
        lit("cold_tgt", pred_target, 32'h104);
        lit("cold_ghr", {28'b0, pred_ghr}, 32'h0);
        next();

        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h104, 4'h0);
        @(negedge clk);
        lit("alloc_mp", {31'b0, mispredict}, 32'h1);
        lit("alloc_red", redirect_pc, 32'h200);
        next();
        idle(32'h100);
        @(negedge clk);
        lit("alloc_cnt", {16'b0, mispred_cnt}, 32'h1);
        lit("alloc_pt", {31'b0, pred_taken}, 32'h1);
        lit("alloc_tgt", pred_target, 32'h200);
        next();

        drive(32'h140, 1'b1, 32'h140, 32'h240, 1'b0, 1'b0, 32'h144, 4'h0);
        @(negedge clk);
        lit("alias_pt", {31'b0, pred_taken}, 32'h0);
        lit("alias_tgt", pred_target, 32'h144);
        lit("alias_mp", {31'b0, mispredict}, 32'h0);
        next();
        idle(32'h100);
        @(negedge clk);
        lit("alias_keep", pred_target, 32'h200);
        next();

        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200, 4'h0);
        next();
        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200, 4'h0);
        @(negedge clk);
        lit("hyst1_red", redirect_pc, 32'h104);
        next();
        @(negedge clk);
        lit("hyst1_pt", {31'b0, pred_taken}, 32'h1);
        next();
        idle(32'h100);
        @(negedge clk);
        lit("hyst2_pt", {31'b0, pred_taken}, 32'h0);
        lit("hyst2_cnt", {16'b0, mispred_cnt}, 32'h3);
        next();

        drive(32'h100, 1'b1, 32'h100, 32'h300, 1'b1, 1'b0, 32'h104, 4'h0);
        @(negedge clk);
        lit("bypass_old", {31'b0, pred_taken}, 32'h0);
        lit("bypass_red", redirect_pc, 32'h300);
        next();
        idle(32'h100);
        @(negedge clk);
        lit("bypass_new", pred_target, 32'h300);
        next();

        drive(32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 32'h10, 1'b0, 1'b1, 32'h10, 4'h0);
        @(negedge clk);
        lit("wrap_tgt", pred_target, 32'h0);
        lit("wrap_red", redirect_pc, 32'h0);
        next();
`endif

        drive(32'h380, 1'b1, 32'h380, 32'h400, 1'b1, 1'b0, 32'h384, 4'h0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        lit("rst_mp", {31'b0, mispredict}, 32'h1);
        lit("rst_cnt", {16'b0, mispred_cnt}, 32'h0);
        next();
        rst_n = 1'b1;
        @(negedge clk);
        lit("rst_discard", {31'b0, pred_taken}, 32'h0);
        next();
        idle(32'h380);
        @(negedge clk);
        lit("rst_first_upd", pred_target, 32'h400);
        lit("rst_first_cnt", {16'b0, mispred_cnt}, 32'h1);
        next();

        drive(32'h500, 1'b1, 32'h500, 32'h600, 1'b1, 1'b0, 32'h504, 4'h0);
        for (int i = 0; i < 65540; i++) next();
        @(negedge clk);
        lit("sat_cnt", {16'b0, mispred_cnt}, 32'hFFFF);
        next();
        next();
        idle(32'h500);
        @(negedge clk);
        lit("sat_hold", {16'b0, mispred_cnt}, 32'hFFFF);
        next();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 clk  input  1  Single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  Reset, asynchronous, active-low.
REQ-003 if_pc  input  32  Fetch-stage PC to predict.
REQ-004 pred_taken  output  1  Predicted taken for if_pc.
REQ-005 pred_target  output  32  Predicted target; equals if_pc+4 when pred_taken=0.
REQ-006 pred_ghr  output  4  Global history at lookup time, to be carried down the pipe (0 when macro absent).
REQ-007 upd_valid  input  1  Execute-stage conditional branch resolved this cycle.
REQ-008 upd_pc, upd_target  input  32 each  Resolved branch PC and computed target.
REQ-009 upd_taken  input  1  Resolved outcome (execute-stage Branch result).
REQ-010 upd_pred_taken, upd_pred_target  input  1/32  Prediction carried with the branch.
REQ-011 upd_ghr  input  4  pred_ghr carried with the branch; ignored when macro absent.
REQ-012 mispredict  output  1  Resolved outcome/target differs from prediction.
REQ-013 redirect_pc  output  32  Correct next PC for fetch on mispredict.
REQ-014 mispred_cnt  output  16  Saturating mispredict count.

Function
REQ-015 Table: 16 entries; each entry holds valid(1), tag(26 = PC[31:6]), target(32), ctr(2).
REQ-016 Entry index = PC[5:2]; ctr index = PC[5:2] XOR ghr with macro, else PC[5:2].
REQ-017 Lookup is combinational, zero latency: hit = valid && tag==if_pc[31:6]; pred_taken = hit && ctr[1]; pred_target = pred_taken ? entry target : if_pc+4.
REQ-018 mispredict = upd_valid && (upd_taken!=upd_pred_taken || (upd_taken && upd_target!=upd_pred_target)); combinational.
REQ-019 redirect_pc = upd_taken ? upd_target : upd_pc+4; value don't-care when mispredict=0.
REQ-020 On a clock edge with upd_valid=1 and tag hit: ctr increments if taken, decrements if not, saturating at 3 and 0; target overwritten with upd_target if taken.
REQ-021 Tag miss and upd_taken=1: allocate (overwrite) the entry: valid=1, tag, target, ctr=2'b10.
REQ-022 Tag miss and upd_taken=0: no table change.
REQ-023 Same-index lookup and update in one cycle: lookup returns pre-update contents; new contents visible next cycle.
REQ-024 mispred_cnt increments by 1 per cycle with mispredict=1; holds at 16'hFFFF.
REQ-025 Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFFFFFC+4 = 0).

Reset
REQ-026 rst_n low immediately clears all valid bits, sets all ctr to 2'b01, mispred_cnt to 0, ghr to 0; targets/tags need no reset.
REQ-027 While rst_n low: pred_taken=0, pred_target=if_pc+4; mispredict still combinational from inputs.
REQ-028 Reset asserted mid-update: update is discarded; release returns to reset state, first update takes effect on first rising edge after release.

Configuration
REQ-029 Macro BP_GSHARE_EN defined: a 4-bit global history register shifts in upd_taken at LSB on every upd_valid edge; ctr index per REQ-016 using ghr for lookup and upd_ghr for update; pred_ghr = ghr.
REQ-030 On mispredict with BP_GSHARE_EN, ghr is loaded with {upd_ghr[2:0], upd_taken} instead of shifting, repairing wrong-path history.
REQ-031 Macro absent: no history register, ctr indexed by PC[5:2], pred_ghr = 0, upd_ghr ignored.

Verification
REQ-032 Cold: after reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-033 Allocate: update pc=0x100, taken, target=0x200, pred_taken=0 -> mispredict=1, redirect_pc=0x200, mispred_cnt=1; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x200.
REQ-034 Hysteresis: entry ctr=2'b11, one not-taken update -> still predicts taken; second not-taken -> predicts not taken, redirect_pc=upd_pc+4.
REQ-035 Alias: entry at 0x100 valid; lookup 0x140 (same index, different tag) -> pred_taken=0; not-taken update for 0x140 leaves 0x100 entry intact.
REQ-036 Saturation/bypass: force 65536 mispredicts -> mispred_cnt=0xFFFF and holds; same-cycle lookup/update at one index returns old prediction.
REQ-037 BP_GSHARE_EN: taken, taken, not-taken updates -> pred_ghr=4'b0110; mispredict with upd_ghr=4'b1010, taken -> ghr=4'b0101.
